divisor_flotante: RTL and testbench

Sequential floating-point divider for the GP02 minifloat format (sign, biased exponent, normalized mantissa with hidden 1). It is the inverse of the multiplier datapath: it subtracts exponents and re-adds the bias, and it divides mantissas with an iterative restoring algorithm. A valid/ready start and a one-cycle done pulse let it sit between an operand source and a result register.

---
 rtl/divisor_flotante.sv | 160 ++++++++++++++++
 tb/tb_divisor_flotante.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_flotante.sv
// divisor_flotante: sequential divider for the sign/biased-exponent/hidden-1
// minifloat format. Exponents are subtracted and re-biased; mantissas are
// divided with a restoring shift-subtract loop, one quotient bit per cycle.
//
// Handshake: an operand pair is accepted on the rising edge where
// i_valid=1 and o_ready=1; o_ready stays low until the result has been
// presented; o_valid is a one-cycle pulse and needs no ready from the sink.
module divisor_flotante #(
  parameter int NB_EXP = 4,
  parameter int NB_MAN = 3,
  parameter int BIAS   = 7,
  localparam int W     = 1 + NB_EXP + NB_MAN
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_dividendo,
  input  logic [W-1:0] i_divisor,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_cociente,
  output logic         o_overflow,
  output logic         o_underflow
);

  localparam int NE = NB_EXP + 2;             // signed working exponent
  localparam int NQ = NB_MAN + 2;             // quotient / remainder width
  localparam int CW = $clog2(NB_MAN + 3);     // iteration counter width
  localparam logic [CW-1:0] LAST_ITER = CW'(NB_MAN + 1);
  localparam logic signed [NE-1:0] EXP_MAX = NE'((1 << NB_EXP) - 1);
  localparam logic signed [NE-1:0] BIAS_S  = NE'(BIAS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    NORMALIZE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [NE-1:0]   e_tmp_q, e_tmp_d;
  logic [NQ-1:0]          r_q, r_d;
  logic [NB_MAN:0]        d_q, d_d;
  logic [NQ-1:0]          q_q, q_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           cociente_q, cociente_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  // Datapath helpers used by the divide and normalize steps
  logic                   r_ge_d;
  logic [NQ-1:0]          r_minus_d;
  logic signed [NE-1:0]   exp_n;
  logic [NB_MAN-1:0]      man_n;

  // State and datapath register bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      e_tmp_q     <= '0;
      r_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      cociente_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      e_tmp_q     <= e_tmp_d;
      r_q         <= r_d;
      d_q         <= d_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      cociente_q  <= cociente_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state and datapath: latch, restoring step, normalize and range check
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    e_tmp_d     = e_tmp_q;
    r_d         = r_q;
    d_d         = d_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    cociente_d  = cociente_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Remainder stays below 2*d, so (r-d)<<1 and r<<1 both fit in NQ bits.
    r_ge_d    = (r_q >= {1'b0, d_q});
    r_minus_d = r_q - {1'b0, d_q};

    // Quotient lies in (0.5, 2): its MSB decides whether a shift is needed.
    if (q_q[NQ-1]) begin
      exp_n = e_tmp_q;
      man_n = q_q[NB_MAN:1];
    end else begin
      exp_n = e_tmp_q - $signed(NE'(1));
      man_n = q_q[NB_MAN-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          sign_d      = i_dividendo[W-1] ^ i_divisor[W-1];
          e_tmp_d     = $signed({2'b00, i_dividendo[W-2:NB_MAN]})
                      - $signed({2'b00, i_divisor[W-2:NB_MAN]}) + BIAS_S;
          r_d         = {2'b01, i_dividendo[NB_MAN-1:0]};
          d_d         = {1'b1, i_divisor[NB_MAN-1:0]};
          q_d         = '0;
          cnt_d       = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = DIVIDE;
        end
      end
      DIVIDE: begin
        q_d   = {q_q[NQ-2:0], r_ge_d};
        r_d   = r_ge_d ? (r_minus_d << 1) : (r_q << 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = NORMALIZE;
        end
      end
      NORMALIZE: begin
        if (exp_n > EXP_MAX) begin
          cociente_d = {sign_q, {(W-1){1'b1}}};
          overflow_d = 1'b1;
        end else if (exp_n[NE-1]) begin
          cociente_d  = {sign_q, {(W-1){1'b0}}};
          underflow_d = 1'b1;
        end else begin
          cociente_d = {sign_q, exp_n[NB_EXP-1:0], man_n};
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_cociente  = cociente_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_divisor_flotante.sv
// tb_divisor_flotante: directed and randomized checks of divisor_flotante
// (E4M3, bias 7) against a value-level reference model and a cycle-count
// timing model of the accept/result handshake.
module tb_divisor_flotante;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic [W-1:0] i_dividendo;
  logic [W-1:0] i_divisor;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_cociente;
  logic         o_overflow;
  logic         o_underflow;

  int n_vec = 0;
  int n_err = 0;

  divisor_flotante dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_dividendo (i_dividendo),
    .i_divisor   (i_divisor),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_cociente  (o_cociente),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {quotient[7:0], overflow, underflow} computed from real values:
  // mantissa quotient truncated to 4 fractional bits, then renormalized.
  function automatic logic [W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ma, mb, q, e, man;
    logic s;
    ma = 8 + int'(a[2:0]);
    mb = 8 + int'(b[2:0]);
    q  = (ma * 16) / mb;               // A/B scaled by 16, truncated
    e  = int'(a[6:3]) - int'(b[6:3]) + 7;
    s  = a[7] ^ b[7];
    if (q >= 16) begin
      man = q / 2 - 8;
    end else begin
      man = q - 8;
      e   = e - 1;
    end
    if (e > 15)     return {s, 7'h7F, 1'b1, 1'b0};
    else if (e < 0) return {s, 7'h00, 1'b0, 1'b1};
    else            return {s, 4'(e), 3'(man), 1'b0, 1'b0};
  endfunction

  // ---------------- scoreboard / timing model ----------------
  // m_cnt: 0 when idle, counts cycles since accept; result registered when
  // it reaches 7, idle again after 8.
  logic [W+1:0] exp_q[$];
  int           m_cnt = 0;
  logic [W-1:0] m_coc = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cnt = 0;
      m_coc = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (i_valid) begin
        exp_q.push_back(ref_div(i_dividendo, i_divisor));
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_cnt = 1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 7) begin
        logic [W+1:0] r;
        r = exp_q.pop_front();
        m_coc = r[W+1:2];
        m_ovf = r[1];
        m_unf = r[0];
      end else if (m_cnt == 8) begin
        m_cnt = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge i_clk) begin
    chk("o_ready",     32'(o_ready),     32'(m_cnt == 0));
    chk("o_valid",     32'(o_valid),     32'(m_cnt == 7));
    chk("o_cociente",  32'(o_cociente),  32'(m_coc));
    chk("o_overflow",  32'(o_overflow),  32'(m_ovf));
    chk("o_underflow", 32'(o_underflow), 32'(m_unf));
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_ready) chk("ready_wait", 32'(o_ready), 32'd1);
    i_valid     = 1'b1;
    i_dividendo = a;
    i_divisor   = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 20);
    chk("latency", 32'(n), 32'd7);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] q,
                              input logic ovf, input logic unf);
    chk(name, 32'(o_cociente), 32'(q));
    chk({name, "_ovf"}, 32'(o_overflow), 32'(ovf));
    chk({name, "_unf"}, 32'(o_underflow), 32'(unf));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_dividendo = '0;
    i_divisor   = '0;

    // Pin the reference model to hand-computed values
    chk("model_2_1",     32'(ref_div(8'h40, 8'h38)), {22'd0, 8'h40, 2'b00});
    chk("model_1_1p5",   32'(ref_div(8'h38, 8'h3C)), {22'd0, 8'h32, 2'b00});
    chk("model_m3_2",    32'(ref_div(8'hC4, 8'h40)), {22'd0, 8'hBC, 2'b00});
    chk("model_m3_m3",   32'(ref_div(8'hC4, 8'hC4)), {22'd0, 8'h38, 2'b00});
    chk("model_ovf",     32'(ref_div(8'h7F, 8'h00)), {22'd0, 8'h7F, 2'b10});
    chk("model_unf",     32'(ref_div(8'h00, 8'h7F)), {22'd0, 8'h00, 2'b01});

    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_q",     32'(o_cociente), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed cases
    run_op(8'h40, 8'h38); check_result("d_2_div_1",   8'h40, 1'b0, 1'b0);
    run_op(8'h38, 8'h3C); check_result("d_1_div_1p5", 8'h32, 1'b0, 1'b0);
    run_op(8'hC4, 8'h40); check_result("d_m3_div_2",  8'hBC, 1'b0, 1'b0);
    run_op(8'hC4, 8'hC4); check_result("d_m3_div_m3", 8'h38, 1'b0, 1'b0);
    run_op(8'h7F, 8'h00); check_result("d_overflow",  8'h7F, 1'b1, 1'b0);
    run_op(8'h00, 8'h7F); check_result("d_underflow", 8'h00, 1'b0, 1'b1);

    // i_valid held high with operands changing every cycle
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      i_dividendo = 8'($urandom_range(0, 255));
      i_divisor   = 8'($urandom_range(0, 255));
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;

    // Reset pulse in the middle of a divide
    i_valid     = 1'b1;
    i_dividendo = 8'h5A;
    i_divisor   = 8'h21;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    run_op(8'h40, 8'h38); check_result("after_rst", 8'h40, 1'b0, 1'b0);

    // Randomized operations with random idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [W+1:0] r;
      logic [W-1:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      r = ref_div(a, b);
      run_op(a, b);
      check_result("rnd", r[W+1:2], r[1], r[0]);
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #1;
    end

    repeat (5) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
